// File: rtl/harmonic_series_acc.sv
// ---------------------------------------------------------------------------
// harmonic_series_acc
//
// Purpose
//   After an accepted start, the block latches a term count n. It then adds
//   ROM[k] for k = 1..n, one term per clock, into an unsigned fixed-point sum
//   Q(SUM_W-FRAC_W).FRAC_W. ROM[k] = round(2^FRAC_W / k) and is built at
//   elaboration.
//   The sum saturates at all ones and sets a sticky overflow flag. It never
//   wraps.
//
// Optional feature (macro HSUM_SQUARED_EN)
//   Adds the mode port and a second table, round(2^FRAC_W / k^2). The mode is
//   latched on the accepting edge and selects the table for the whole job.
//   Without the macro the block behaves as if mode = 0.
//
// Parameters
//   N_W     width of n, so at most 2^N_W-1 terms
//   FRAC_W  fraction bits of the ROM entries and of sum
//   SUM_W   width of sum; must satisfy SUM_W > FRAC_W
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      job request
//   n          term count, sampled on the accepting edge only
//   mode       0 = 1/k, 1 = 1/k^2 (only with HSUM_SQUARED_EN)
//   ready      high in IDLE
//   busy       high in ACC and DONE
//   done       one-cycle pulse; sum and ovf are final while it is high
//   sum        accumulated result; holds until the next accepted start
//   ovf        sticky saturation flag; cleared by the next accepted start
//   dbg_state  current FSM state (IDLE=0, ACC=1, DONE=2)
//
// Handshake
//   A request is accepted on any rising edge where start=1 and ready=1.
//   While busy=1, start is ignored and has no effect on n_q, sum or timing.
//   start may be held high: the next job is accepted on the edge that leaves
//   the single IDLE cycle following DONE.
// ---------------------------------------------------------------------------
module harmonic_series_acc #(
    parameter int N_W    = 4,
    parameter int FRAC_W = 16,
    parameter int SUM_W  = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n,
`ifdef HSUM_SQUARED_EN
    input  logic             mode,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int DEPTH = 1 << N_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Table entry generator. It is only ever called with constant
    // arguments, so every entry folds to a constant at elaboration.
    // The rounding is half up: floor((2^FRAC_W + d/2) / d).
    function automatic logic [FRAC_W:0] recip_entry(input int kk, input bit squared);
        longint d;
        longint q;
        if (kk == 0) begin
            return '0;
        end
        d = squared ? longint'(kk) * longint'(kk) : longint'(kk);
        q = ((longint'(1) << FRAC_W) + d / 2) / d;
        return q[FRAC_W:0];
    endfunction

    logic [FRAC_W:0] rom_recip [DEPTH];
`ifdef HSUM_SQUARED_EN
    logic [FRAC_W:0] rom_sq    [DEPTH];
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom_recip[g] = recip_entry(g, 1'b0);
`ifdef HSUM_SQUARED_EN
        assign rom_sq[g]    = recip_entry(g, 1'b1);
`endif
    end

    state_t           state_q, state_d;
    logic [N_W-1:0]   n_q;
    logic [N_W-1:0]   k_q;
    logic [SUM_W-1:0] sum_q;
    logic             ovf_q;
    logic             done_q;
`ifdef HSUM_SQUARED_EN
    logic             mode_q;
`endif

    logic [FRAC_W:0]  term;
    logic [SUM_W:0]   sum_ext;

    // Term selection and the widened add.
    // The result is SUM_W+1 bits wide, so its top bit set means it exceeded
    // 2^SUM_W-1.
    always_comb begin
        term = rom_recip[k_q];
`ifdef HSUM_SQUARED_EN
        if (mode_q) begin
            term = rom_sq[k_q];
        end
`endif
        sum_ext = {1'b0, sum_q} + {1'b0, SUM_W'(term)};
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (n == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                // This edge adds the last term.
                if (k_q == n_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and the registered done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q    <= '0;
            k_q    <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef HSUM_SQUARED_EN
            mode_q <= 1'b0;
`endif
        end else begin
            // DONE always leaves after one cycle, so this is a single pulse.
            done_q <= (state_d == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        n_q   <= n;
                        k_q   <= N_W'(1);
                        sum_q <= '0;
                        ovf_q <= 1'b0;
`ifdef HSUM_SQUARED_EN
                        mode_q <= mode;
`endif
                    end
                end
                ST_ACC: begin
                    // Once saturated, the sum stays pinned at all ones.
                    if (ovf_q || sum_ext[SUM_W]) begin
                        sum_q <= '1;
                        ovf_q <= 1'b1;
                    end else begin
                        sum_q <= sum_ext[SUM_W-1:0];
                    end
                    // k stops on the last term.
                    // So n = 2^N_W-1 never wraps k.
                    if (k_q != n_q) begin
                        k_q <= k_q + N_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_ACC) || (state_q == ST_DONE);
    assign done      = done_q;
    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_harmonic_series_acc.sv
module tb_harmonic_series_acc;

  localparam int N_W      = 4;
  localparam int FRAC_W   = 16;
  localparam int SUM_W    = 19;
  localparam int SUM_W_NR = 17;
  localparam int MAX_WAIT = 40;

  // ---------------- clock / reset / signals ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [N_W-1:0]      n;
  logic                mode;
  logic                ready, busy, done, ovf;
  logic [SUM_W-1:0]    sum;
  logic [1:0]          dbg_state;
  logic                ready_nr, busy_nr, done_nr, ovf_nr;
  logic [SUM_W_NR-1:0] sum_nr;
  logic [1:0]          dbg_state_nr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SUM_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  harmonic_series_acc #(.N_W(N_W), .FRAC_W(FRAC_W), .SUM_W(SUM_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .n(n),
`ifdef HSUM_SQUARED_EN
    .mode(mode),
`endif
    .ready(ready), .busy(busy), .done(done), .sum(sum), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  // Narrow-sum instance sharing the same inputs, used for saturation.
  harmonic_series_acc #(.N_W(N_W), .FRAC_W(FRAC_W), .SUM_W(SUM_W_NR)) u_dut_nr (
    .clk(clk), .reset(reset), .start(start), .n(n),
`ifdef HSUM_SQUARED_EN
    .mode(mode),
`endif
    .ready(ready_nr), .busy(busy_nr), .done(done_nr), .sum(sum_nr), .ovf(ovf_nr),
    .dbg_state(dbg_state_nr)
  );

  // ---------------- reference model ----------------
  // Sum of round(2^FRAC_W / d) for k = 1..nn, where d = k or k^2.
  // The accumulation saturates at 2^sw-1.
  function automatic longint model_sum(input int nn, input int sw, input bit sq, output bit ov);
    longint acc, lim, d;
    acc = 0;
    ov  = 1'b0;
    lim = (longint'(1) << sw) - 1;
    for (int k = 1; k <= nn; k++) begin
      d = sq ? longint'(k * k) : longint'(k);
      acc += ((longint'(1) << FRAC_W) + d / 2) / d;
      if (acc > lim) begin
        acc = lim;
        ov  = 1'b1;
      end
    end
    return acc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one job and waits for done.
  // While it waits it scrambles n and mode, which must have no effect.
  // lat counts the edges after the accepting edge until done is seen.
  task automatic run_job(input int jn, input bit jmode, output int lat,
                         output logic [SUM_W-1:0] s, output logic o,
                         output logic [SUM_W_NR-1:0] s_nr, output logic o_nr,
                         output bit timeout);
    start = 1'b1;
    n     = N_W'(jn);
    mode  = jmode;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < MAX_WAIT) begin
      n    = N_W'($urandom_range(0, (1 << N_W) - 1));
      mode = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    timeout = !done;
    s       = sum;
    o       = ovf;
    s_nr    = sum_nr;
    o_nr    = ovf_nr;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    n     = 4'd5;
    mode  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    n_checks++;
    if (sum !== '0 || ovf !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: sum=%0d ovf=%0b done=%0b, required 0/0/0", sum, ovf, done);
    end
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%0b busy=%0b, required 1/0", ready, busy);
    end
  endtask

  task automatic test_basic();
    int lat; logic [SUM_W-1:0] s; logic o; logic [SUM_W_NR-1:0] snr; logic onr; bit to;
    run_job(4, 1'b0, lat, s, o, snr, onr, to);
    n_checks++;
    if (to || lat != 4) begin
      n_fail++;
      $display("FAIL basic_latency: lat=%0d timeout=%0b, required 4", lat, to);
    end
    n_checks++;
    if (s !== 19'd136533 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: sum=%0d ovf=%0b, required 136533/0", s, o);
    end
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done_width: done=%0b ready=%0b, required 0/1", done, ready);
    end
    tick();
    tick();
    n_checks++;
    if (sum !== 19'd136533) begin
      n_fail++;
      $display("FAIL basic_hold: sum=%0d, required 136533", sum);
    end
  endtask

  task automatic test_zero();
    start = 1'b1;
    n     = '0;
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || sum !== '0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%0b busy=%0b sum=%0d ovf=%0b, required 1/1/0/0",
               done, busy, sum, ovf);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_busy_width: done=%0b busy=%0b ready=%0b, required 0/0/1",
               done, busy, ready);
    end
  endtask

  task automatic test_saturation();
    int lat; logic [SUM_W-1:0] s; logic o; logic [SUM_W_NR-1:0] snr; logic onr; bit to;
    longint exp_wide; bit ov_wide;
    run_job(15, 1'b0, lat, s, o, snr, onr, to);
    exp_wide = model_sum(15, SUM_W, 1'b0, ov_wide);
    n_checks++;
    if (to || lat != 15) begin
      n_fail++;
      $display("FAIL sat_latency: lat=%0d timeout=%0b, required 15", lat, to);
    end
    n_checks++;
    if (snr !== 17'd131071 || onr !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_narrow: sum=%0d ovf=%0b, required 131071/1", snr, onr);
    end
    n_checks++;
    if (s !== SUM_W'(exp_wide) || o !== ov_wide) begin
      n_fail++;
      $display("FAIL sat_wide_n15: sum=%0d ovf=%0b, required %0d/%0b", s, o, exp_wide, ov_wide);
    end
    run_job(1, 1'b0, lat, s, o, snr, onr, to);
    n_checks++;
    if (to || snr !== 17'd65536 || onr !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: sum=%0d ovf=%0b timeout=%0b, required 65536/0", snr, onr, to);
    end
  endtask

  task automatic test_busy_ignore();
    int lat; logic [SUM_W-1:0] s; logic o; logic [SUM_W_NR-1:0] snr; logic onr; bit to;
    longint e; bit eo;
    int seen_done; int not_ready;
    // A start pulse in the middle of a job must not change that job.
    start = 1'b1; n = 4'd5; mode = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; n = 4'd2;
    tick();
    start = 1'b0;
    lat = 2;
    while (!done && lat < MAX_WAIT) begin tick(); lat++; end
    e = model_sum(5, SUM_W, 1'b0, eo);
    n_checks++;
    if (!done || lat != 5 || sum !== SUM_W'(e)) begin
      n_fail++;
      $display("FAIL busy_start_ignored: lat=%0d sum=%0d, required 5/%0d", lat, sum, e);
    end
    tick();
    // A job aborted by reset, with a second start pulsed while it was busy.
    start = 1'b1; n = 4'd15;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; n = 4'd2;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (sum !== '0 || ovf !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reset: sum=%0d ovf=%0b done=%0b ready=%0b, required 0/0/0/1",
               sum, ovf, done, ready);
    end
    seen_done = 0; not_ready = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) seen_done++;
      if (!ready) not_ready++;
    end
    n_checks++;
    if (seen_done != 0 || not_ready != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: done_pulses=%0d busy_cycles=%0d, required 0/0",
               seen_done, not_ready);
    end
    run_job(2, 1'b0, lat, s, o, snr, onr, to);
    n_checks++;
    if (to || lat != 2 || s !== 19'd98304 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_job: lat=%0d sum=%0d ovf=%0b, required 2/98304/0", lat, s, o);
    end
  endtask

`ifdef HSUM_SQUARED_EN
  task automatic test_mode();
    int lat; logic [SUM_W-1:0] s; logic o; logic [SUM_W_NR-1:0] snr; logic onr; bit to;
    run_job(3, 1'b1, lat, s, o, snr, onr, to);
    n_checks++;
    if (to || lat != 3 || s !== 19'd89202 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_sq_n3: lat=%0d sum=%0d ovf=%0b, required 3/89202/0", lat, s, o);
    end
  endtask
`endif

  task automatic test_random();
    int lat; logic [SUM_W-1:0] s; logic o; logic [SUM_W_NR-1:0] snr; logic onr; bit to;
    int jn; bit jm; longint e, enr; bit eo, eonr;
    for (int i = 0; i < 10; i++) begin
      jn = $urandom_range(0, (1 << N_W) - 1);
`ifdef HSUM_SQUARED_EN
      jm = 1'($urandom_range(0, 1));
`else
      jm = 1'b0;
`endif
      run_job(jn, jm, lat, s, o, snr, onr, to);
      e   = model_sum(jn, SUM_W, jm, eo);
      enr = model_sum(jn, SUM_W_NR, jm, eonr);
      n_checks++;
      if (to || lat != jn || s !== SUM_W'(e) || o !== eo) begin
        n_fail++;
        $display("FAIL random_job n=%0d mode=%0b: lat=%0d sum=%0d ovf=%0b, required %0d/%0d/%0b",
                 jn, jm, lat, s, o, jn, e, eo);
      end
      n_checks++;
      if (snr !== SUM_W_NR'(enr) || onr !== eonr) begin
        n_fail++;
        $display("FAIL random_narrow n=%0d: sum=%0d ovf=%0b, required %0d/%0b",
                 jn, snr, onr, enr, eonr);
      end
    end
  endtask

  task automatic test_back_to_back();
    int last_done, n_done;
    logic [SUM_W-1:0] e;
    for (int j = 0; j < 4; j++) exp_q.push_back(19'd98304);
    start = 1'b1; n = 4'd2; mode = 1'b0;
    last_done = -1; n_done = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (done) begin
        n_done++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++;
        if (sum !== e) begin
          n_fail++;
          $display("FAIL b2b_sum: sum=%0d, required %0d", sum, e);
        end
        if (last_done >= 0) begin
          n_checks++;
          if (c - last_done != 4) begin
            n_fail++;
            $display("FAIL b2b_period: period=%0d, required 4", c - last_done);
          end
        end
        last_done = c;
      end
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (n_done != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: done_pulses=%0d, required 4", n_done);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; n = '0; mode = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_saturation();
    test_busy_ignore();
`ifdef HSUM_SQUARED_EN
    test_mode();
`endif
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
